dram_data_responder: RTL and testbench

DRAM_DATA_RESPONDER -- requirements
Module: dram_data_responder

---
 rtl/dram_pack.sv | 15 +
 rtl/dram_data_responder_if.sv | 21 ++
 rtl/dram_burst_store.sv | 30 +++
 rtl/dram_data_responder.sv | 109 ++++++++++
 tb/tb_dram_data_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dram_pack.sv
// dram_pack: shared DRAM responder constants, FSM state enum and burst entry type.
//   CONFIGURED_DQ_BITS : default DQ bus width per beat
//   BURST_LEN, RL, WL  : beats per burst, read latency, write latency (cycles)
//   state_t            : responder FSM states
//   entry_t            : one stored burst at the configured DQ width
package dram_pack;
    localparam int CONFIGURED_DQ_BITS = 8;
    localparam int BURST_LEN = 8;
    localparam int RL = 4;
    localparam int WL = 2;
    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_PRE, WR_DATA, RD_WAIT, RD_PRE, RD_DATA, RD_POST
    } state_t;
    typedef logic [BURST_LEN*CONFIGURED_DQ_BITS-1:0] entry_t;
endpackage

// File: rtl/dram_data_responder_if.sv
// dram_data_responder_if: command/status bundle between a host and the DRAM data responder.
//   wr_cmd, rd_cmd : one-cycle burst command pulses
//   col_addr       : burst entry index, sampled with the command
//   bc             : burst chop request (only with BURST_CHOP_EN defined)
//   busy, err      : responder status
//   master = command issuer, slave = responder
interface dram_data_responder_if #(parameter int DEPTH = 16);
    logic wr_cmd;
    logic rd_cmd;
    logic [$clog2(DEPTH)-1:0] col_addr;
    logic busy;
    logic err;
`ifdef BURST_CHOP_EN
    logic bc;
    modport master (output wr_cmd, rd_cmd, col_addr, bc, input busy, err);
    modport slave (input wr_cmd, rd_cmd, col_addr, bc, output busy, err);
`else
    modport master (output wr_cmd, rd_cmd, col_addr, input busy, err);
    modport slave (input wr_cmd, rd_cmd, col_addr, output busy, err);
`endif
endinterface

// File: rtl/dram_burst_store.sv
// dram_burst_store: burst entry storage, one half-enabled write port and one combinational read port.
//   clk, rst_n : clock, asynchronous active-low clear of every entry
//   we[1:0]    : write enable for the lower / upper half of the entry
//   waddr      : write entry index, wdata : entry data
//   raddr      : read entry index,  rdata : entry data (combinational)
module dram_burst_store #(
    parameter int W = 64,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    localparam int H = W / 2;
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we[0]) mem[waddr][H-1:0] <= wdata[H-1:0];
            if (we[1]) mem[waddr][W-1:H] <= wdata[W-1:H];
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/dram_data_responder.sv
// dram_data_responder: DRAM-side burst responder capturing write bursts and replaying them with DQS strobes.
//   CLK, nRST     : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : wr_cmd, rd_cmd, col_addr, [bc], busy, err
//   DQ            : data beats, driven only in read preamble/data
//   DQS_t, DQS_c  : complementary strobe, driven only in read preamble/data/postamble
//   BURST_CHOP_EN : when defined, bc=1 shortens a burst to beats 0-3
module dram_data_responder
    import dram_pack::*;
#(
    parameter int WORD_W = 32,
    parameter int DQ_W = CONFIGURED_DQ_BITS,
    parameter int DEPTH = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    dram_data_responder_if.slave  bus,
    inout  wire  [DQ_W-1:0]       DQ,
    inout  wire                   DQS_t,
    inout  wire                   DQS_c
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = BURST_LEN * DQ_W;
    localparam int CW = $clog2(BURST_LEN);
    if (WORD_W > EW) begin : g_width_check
        $error("host word wider than a burst entry");
    end
    state_t state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] col;
    logic [EW-1:0] wbuf, wdata, rdata;
    logic [1:0] we;
    logic idle, acc_wr, acc_rd, last, dq_oe, dqs_oe, dqs_v;
`ifdef BURST_CHOP_EN
    logic chop;
    assign last = cnt == (chop ? CW'(3) : CW'(BURST_LEN-1));
    assign we = {2{state == WR_DATA && last}} & {~chop, 1'b1};
`else
    assign last = cnt == CW'(BURST_LEN-1);
    assign we = {2{state == WR_DATA && last}};
`endif
    assign idle = state == IDLE;
    assign acc_wr = idle & bus.wr_cmd & ~bus.rd_cmd;
    assign acc_rd = idle & bus.rd_cmd & ~bus.wr_cmd;
    assign bus.busy = ~idle;
    // The beat on DQ now is merged in so the last beat commits on the edge that samples it.
    always_comb begin
        wdata = wbuf;
        wdata[cnt*DQ_W +: DQ_W] = DQ;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt <= '0;
            col <= '0;
            wbuf <= '0;
            bus.err <= 1'b0;
`ifdef BURST_CHOP_EN
            chop <= 1'b0;
`endif
        end else begin
            bus.err <= (~idle & (bus.wr_cmd | bus.rd_cmd)) | (idle & bus.wr_cmd & bus.rd_cmd);
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (acc_wr | acc_rd) begin
                        state <= acc_wr ? WR_WAIT : RD_WAIT;
                        col <= bus.col_addr;
`ifdef BURST_CHOP_EN
                        chop <= bus.bc;
`endif
                    end
                end
                WR_WAIT: if (cnt == CW'(WL-1)) begin
                    state <= WR_PRE;
                    cnt <= '0;
                end
                WR_PRE: begin
                    state <= WR_DATA;
                    cnt <= '0;
                end
                WR_DATA: begin
                    wbuf <= wdata;
                    if (last) state <= IDLE;
                end
                RD_WAIT: if (cnt == CW'(RL-1)) begin
                    state <= RD_PRE;
                    cnt <= '0;
                end
                RD_PRE: begin
                    state <= RD_DATA;
                    cnt <= '0;
                end
                RD_DATA: if (last) state <= RD_POST;
                default: state <= IDLE;
            endcase
        end
    end
    dram_burst_store #(.W(EW), .DEPTH(DEPTH)) u_store (
        .clk(CLK), .rst_n(nRST), .we(we), .waddr(col), .wdata(wdata), .raddr(col), .rdata(rdata)
    );
    // Strobe is high on even beats, low in preamble and postamble.
    assign dq_oe = state == RD_PRE || state == RD_DATA;
    assign dqs_oe = dq_oe || state == RD_POST;
    assign dqs_v = state == RD_DATA && !cnt[0];
    assign DQ = dq_oe ? (state == RD_DATA ? rdata[cnt*DQ_W +: DQ_W] : '0) : 'z;
    assign DQS_t = dqs_oe ? dqs_v : 1'bz;
    assign DQS_c = dqs_oe ? ~dqs_v : 1'bz;
endmodule

// File: tb/tb_dram_data_responder.sv
// tb_dram_data_responder: table, directed and random checks of dram_data_responder against a burst memory model.
module tb_dram_data_responder;
    import dram_pack::*;
    typedef struct {
        logic        rd;
        logic [3:0]  col;
        logic [63:0] data;
        logic        bc;
        logic [63:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    wire [7:0] dq;
    wire dqs_t, dqs_c;
    logic [7:0] tb_dq;
    logic tb_oe;
    int total = 0;
    int bad = 0;
    logic [63:0] mem_m [16];
    vec_t vecs[$];
    dram_data_responder_if #(.DEPTH(16)) bus ();
    dram_data_responder #(.WORD_W(32), .DQ_W(8), .DEPTH(16)) dut (
        .CLK(clk), .nRST(rst_n), .bus(bus), .DQ(dq), .DQS_t(dqs_t), .DQS_c(dqs_c)
    );
    assign dq = tb_oe ? tb_dq : 8'hzz;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] col, input logic [63:0] d, input logic chop, input int inj, input string tag);
        int nb;
        logic [15:0] bv, ebv, ev, eev;
        nb = chop ? 4 : BURST_LEN;
        bv = '0; ebv = '0; ev = '0; eev = '0;
        bus.col_addr = col;
        bus.wr_cmd = 1'b1;
`ifdef BURST_CHOP_EN
        bus.bc = chop;
`endif
        @(posedge clk);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            bv[n-1] = bus.busy;
            ev[n-1] = bus.err;
            ebv[n-1] = n <= WL + 1 + nb;
            eev[n-1] = inj != 0 && n == inj + 1;
            bus.wr_cmd = 1'b0;
            bus.rd_cmd = inj != 0 && n == inj;
            tb_oe = n >= WL + 2 && n < WL + 2 + nb;
            tb_dq = tb_oe ? d[((n - WL - 2) & 7) * 8 +: 8] : 8'h00;
        end
        if (chop) mem_m[col][31:0] = d[31:0];
        else mem_m[col] = d;
        check({"wr_busy_", tag}, 64'(bv), 64'(ebv));
        check({"wr_err_", tag}, 64'(ev), 64'(eev));
    endtask

    task automatic do_read(input logic [3:0] col, input logic chop, input int inj, input logic [63:0] exp, input string tag);
        int nb, dqbad;
        logic [63:0] got;
        logic [31:0] code, ecode;
        logic [15:0] bv, ebv, ev, eev;
        nb = chop ? 4 : BURST_LEN;
        got = '0; code = '0; ecode = '0; bv = '0; ebv = '0; ev = '0; eev = '0; dqbad = 0;
        bus.col_addr = col;
        bus.rd_cmd = 1'b1;
`ifdef BURST_CHOP_EN
        bus.bc = chop;
`endif
        @(posedge clk);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            code[2*(n-1) +: 2] = (dqs_t === dqs_c) ? 2'd0 : (dqs_t === 1'b0 ? 2'd1 : 2'd2);
            if (n >= RL + 2 && n < RL + 2 + nb) begin
                got[(n - RL - 2) * 8 +: 8] = dq;
                ecode[2*(n-1) +: 2] = ((n - RL - 2) % 2 == 0) ? 2'd2 : 2'd1;
            end else if (n == RL + 1 || n == RL + 2 + nb) begin
                ecode[2*(n-1) +: 2] = 2'd1;
                if (n == RL + 1 && dq !== 8'h00) dqbad++;
            end
            if (n != RL + 1 && !(n >= RL + 2 && n < RL + 2 + nb) && !(dq === 8'h00 || dq === 8'hzz)) dqbad++;
            bv[n-1] = bus.busy;
            ev[n-1] = bus.err;
            ebv[n-1] = n <= RL + 2 + nb;
            eev[n-1] = inj != 0 && n == inj + 1;
            bus.rd_cmd = 1'b0;
            bus.wr_cmd = inj != 0 && n == inj;
        end
        check({"rd_data_", tag}, got, exp);
        check({"rd_dqs_", tag}, 64'(code), 64'(ecode));
        check({"rd_dqfree_", tag}, 64'(dqbad), 64'd0);
        check({"rd_busy_", tag}, 64'(bv), 64'(ebv));
        check({"rd_err_", tag}, 64'(ev), 64'(eev));
    endtask

    initial begin
        logic [3:0] rc;
        logic [63:0] rdat;
        logic rch;
        int rinj, nb;
        rst_n = 1'b0;
        bus.wr_cmd = 1'b0;
        bus.rd_cmd = 1'b0;
        bus.col_addr = '0;
`ifdef BURST_CHOP_EN
        bus.bc = 1'b0;
`endif
        tb_oe = 1'b0;
        tb_dq = 8'h00;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_dqs_released", 64'(dqs_t === dqs_c), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{1'b0, 4'd3, 64'h8877665544332211, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 4'd3, 64'h0, 1'b0, 64'h8877665544332211});
        vecs.push_back('{1'b1, 4'd0, 64'h0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 4'd15, 64'hFFFF0000A5A55A5A, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 4'd15, 64'h0, 1'b0, 64'hFFFF0000A5A55A5A});
        vecs.push_back('{1'b0, 4'd0, 64'h0123456789ABCDEF, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 4'd0, 64'h0, 1'b0, 64'h0123456789ABCDEF});
        vecs.push_back('{1'b1, 4'd3, 64'h0, 1'b0, 64'h8877665544332211});
`ifdef BURST_CHOP_EN
        vecs.push_back('{1'b0, 4'd3, 64'hDEADBEEFA4A3A2A1, 1'b1, 64'h0});
        vecs.push_back('{1'b1, 4'd3, 64'h0, 1'b0, 64'h88776655A4A3A2A1});
        vecs.push_back('{1'b1, 4'd3, 64'h0, 1'b1, 64'h00000000A4A3A2A1});
`endif
        foreach (vecs[i]) begin
            if (vecs[i].rd) do_read(vecs[i].col, vecs[i].bc, 0, vecs[i].exp, $sformatf("v%0d", i));
            else do_write(vecs[i].col, vecs[i].data, vecs[i].bc, 0, $sformatf("v%0d", i));
        end

        do_write(4'd3, 64'h8877665544332211, 1'b0, 8, "busy_rd");
        do_read(4'd3, 1'b0, 0, 64'h8877665544332211, "after_busy_rd");
        do_read(4'd3, 1'b0, 14, 64'h8877665544332211, "post_wr_inj");

        bus.col_addr = 4'd3;
        bus.wr_cmd = 1'b1;
        bus.rd_cmd = 1'b1;
        tb_oe = 1'b1;
        tb_dq = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        bus.wr_cmd = 1'b0;
        bus.rd_cmd = 1'b0;
        check("both_err", 64'(bus.err), 64'd1);
        check("both_busy", 64'(bus.busy), 64'd0);
        repeat (12) @(negedge clk);
        check("both_err_once", 64'(bus.err), 64'd0);
        tb_oe = 1'b0;
        do_read(4'd3, 1'b0, 0, mem_m[3], "both_unchanged");

        bus.col_addr = 4'd3;
        bus.rd_cmd = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            bus.rd_cmd = 1'b0;
        end
        check("beat2_before_rst", 64'(dq), 64'h33);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_dqs", 64'(dqs_t === dqs_c), 64'd1);
        check("rst_mid_dq", 64'(dq === 8'h00 || dq === 8'hzz), 64'd1);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        @(negedge clk);
        do_read(4'd3, 1'b0, 0, 64'h0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 3));
            rdat = {$urandom, $urandom};
`ifdef BURST_CHOP_EN
            rch = 1'($urandom_range(0, 1));
`else
            rch = 1'b0;
`endif
            nb = rch ? 4 : BURST_LEN;
            if ($urandom_range(0, 1) == 0) begin
                rinj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, WL + 1 + nb)) : 0;
                do_write(rc, rdat, rch, rinj, $sformatf("r%0d", i));
            end else begin
                rinj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RL + 2 + nb)) : 0;
                do_read(rc, rch, rinj, rch ? {32'h0, mem_m[rc][31:0]} : mem_m[rc], $sformatf("r%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
